// File: rtl/uparc_imuldiv_ctrl_if.sv
// Decode/execute-side signal bundle of the multiply/divide sequencer.
// The master (pipeline) issues ops and operands; the slave (sequencer)
// returns hazard stall, MFHI/MFLO results and busy status.
interface uparc_imuldiv_ctrl_if #(
   parameter int REG_WIDTH = 32
);
   logic                 i_core_stall;
   logic                 i_nullify;
   logic [3:0]           i_op;
   logic [REG_WIDTH-1:0] i_rs_val;
   logic [REG_WIDTH-1:0] i_rt_val;
   logic                 o_stall;
   logic [REG_WIDTH-1:0] o_rd_val;
   logic                 o_rd_valid;
   logic                 o_busy;

   modport master (
      output i_core_stall, i_nullify, i_op, i_rs_val, i_rt_val,
      input  o_stall, o_rd_val, o_rd_valid, o_busy
   );

   modport slave (
      input  i_core_stall, i_nullify, i_op, i_rs_val, i_rt_val,
      output o_stall, o_rd_val, o_rd_valid, o_busy
   );
endinterface

// File: rtl/uparc_imuldiv_ctrl.sv
// Integer multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide on magnitudes over the shared HI/LO pair, sign fix-up
// in a final cycle, hazard stall generation and MFHI/MFLO return path.
module uparc_imuldiv_ctrl #(
   parameter int REG_WIDTH = 32,
   parameter int CNT_WIDTH = 5
) (
   input logic                 clk,
   input logic                 rst,
   uparc_imuldiv_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MFHI  = 4'd7,
      OP_MFLO  = 4'd8
   } op_e;

   state_e                 state;
   logic [REG_WIDTH-1:0]   hi;
   logic [REG_WIDTH-1:0]   lo;
   logic [REG_WIDTH-1:0]   opa;       // multiplicand or divisor magnitude
   logic [CNT_WIDTH-1:0]   cnt;
   logic                   fix_mul;   // FIX applies the 64-bit product negate
   logic                   neg_lo;    // negate product / quotient
   logic                   neg_hi;    // negate remainder
   logic                   busy_q;
   logic [REG_WIDTH-1:0]   rd_val_q;
   logic                   rd_valid_q;

   logic                   op_valid;
   logic                   stall;
   logic                   accept;
   logic                   is_signed;
   logic                   rs_neg;
   logic                   rt_neg;
   logic [REG_WIDTH-1:0]   rs_mag;
   logic [REG_WIDTH-1:0]   rt_mag;
   logic [REG_WIDTH:0]     mul_sum;
   logic [REG_WIDTH:0]     div_shift;
   logic                   div_ge;
   logic [REG_WIDTH-1:0]   div_diff;
   logic [2*REG_WIDTH-1:0] prod_neg;

   // Op qualification, hazard stall, operand magnitudes and datapath step values
   always_comb begin
      op_valid  = 1'b0;
      stall     = 1'b0;
      accept    = 1'b0;
      is_signed = 1'b0;
      rs_neg    = 1'b0;
      rt_neg    = 1'b0;
      rs_mag    = bus.i_rs_val;
      rt_mag    = bus.i_rt_val;
      mul_sum   = '0;
      div_shift = '0;
      div_ge    = 1'b0;
      div_diff  = '0;
      prod_neg  = '0;

      op_valid  = (bus.i_op != OP_NONE) && (bus.i_op <= OP_MFLO);
      stall     = busy_q && op_valid && !bus.i_nullify;
      accept    = !bus.i_core_stall && !stall && !bus.i_nullify && op_valid;

      is_signed = (bus.i_op == OP_MULT) || (bus.i_op == OP_DIV);
      rs_neg    = is_signed && bus.i_rs_val[REG_WIDTH-1];
      rt_neg    = is_signed && bus.i_rt_val[REG_WIDTH-1];
      rs_mag    = rs_neg ? -bus.i_rs_val : bus.i_rs_val;
      rt_mag    = rt_neg ? -bus.i_rt_val : bus.i_rt_val;

      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opa} : '0);
      // Partial remainder never exceeds 2*divisor, so W+1 bits suffice and
      // the low W bits of the difference are exact whenever it is taken.
      div_shift = {hi, lo[REG_WIDTH-1]};
      div_ge    = div_shift >= {1'b0, opa};
      div_diff  = div_shift[REG_WIDTH-1:0] - opa;
      prod_neg  = -{hi, lo};
   end

   assign bus.o_stall    = stall;
   assign bus.o_busy     = busy_q;
   assign bus.o_rd_val   = rd_val_q;
   assign bus.o_rd_valid = rd_valid_q;

   // Sequencer FSM, HI/LO datapath and registered MF result pair
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         hi         <= '0;
         lo         <= '0;
         opa        <= '0;
         cnt        <= '0;
         fix_mul    <= 1'b0;
         neg_lo     <= 1'b0;
         neg_hi     <= 1'b0;
         busy_q     <= 1'b0;
         rd_val_q   <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         if (accept && ((bus.i_op == OP_MFHI) || (bus.i_op == OP_MFLO))) begin
            rd_val_q   <= (bus.i_op == OP_MFHI) ? hi : lo;
            rd_valid_q <= 1'b1;
         end else if (!bus.i_core_stall) begin
            rd_val_q   <= '0;
            rd_valid_q <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  case (bus.i_op)
                     OP_MULT, OP_MULTU: begin
                        state   <= MUL;
                        busy_q  <= 1'b1;
                        cnt     <= CNT_WIDTH'(REG_WIDTH - 1);
                        hi      <= '0;
                        lo      <= rt_mag;
                        opa     <= rs_mag;
                        fix_mul <= 1'b1;
                        neg_lo  <= rs_neg ^ rt_neg;
                        neg_hi  <= 1'b0;
                     end
                     OP_DIV, OP_DIVU: begin
                        // Divide by zero leaves quotient all-ones and the
                        // remainder as |rs| with rs's sign, i.e. rs itself.
                        state   <= DIV;
                        busy_q  <= 1'b1;
                        cnt     <= CNT_WIDTH'(REG_WIDTH - 1);
                        hi      <= '0;
                        lo      <= rs_mag;
                        opa     <= rt_mag;
                        fix_mul <= 1'b0;
                        neg_lo  <= (rs_neg ^ rt_neg) && (bus.i_rt_val != '0);
                        neg_hi  <= rs_neg;
                     end
                     OP_MTHI: hi <= bus.i_rs_val;
                     OP_MTLO: lo <= bus.i_rs_val;
                     default: ;
                  endcase
               end
            end
            MUL: begin
               {hi, lo} <= {mul_sum, lo[REG_WIDTH-1:1]};
               if (cnt == '0) state <= FIX;
               else           cnt   <= cnt - CNT_WIDTH'(1);
            end
            DIV: begin
               if (div_ge) begin
                  hi <= div_diff;
                  lo <= {lo[REG_WIDTH-2:0], 1'b1};
               end else begin
                  hi <= div_shift[REG_WIDTH-1:0];
                  lo <= {lo[REG_WIDTH-2:0], 1'b0};
               end
               if (cnt == '0) state <= FIX;
               else           cnt   <= cnt - CNT_WIDTH'(1);
            end
            FIX: begin
               if (fix_mul) begin
                  if (neg_lo) {hi, lo} <= prod_neg;
               end else begin
                  if (neg_lo) lo <= -lo;
                  if (neg_hi) hi <= -hi;
               end
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uparc_imuldiv_ctrl.sv
// Self-checking bench for uparc_imuldiv_ctrl. A behavioural HI/LO model
// computes expected results; MF reads push the expected word to a queue
// that is popped when the DUT returns o_rd_val.
module tb_uparc_imuldiv_ctrl;
   localparam int W = 32;
   localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3,
                          DIVU = 4'd4, MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7,
                          MFLO = 4'd8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uparc_imuldiv_ctrl_if #(.REG_WIDTH(W)) bus ();
   uparc_imuldiv_ctrl #(.REG_WIDTH(W), .CNT_WIDTH(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;
   logic [W-1:0] sb_q[$];
   logic [W-1:0] exp_v;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
      bus.i_op     = op;
      bus.i_rs_val = rs;
      bus.i_rt_val = rt;
   endtask

   function automatic void model_apply(input logic [3:0] op, input logic [W-1:0] rs,
                                       input logic [W-1:0] rt);
      longint sp;
      logic [63:0] up;
      int a, b;
      a = rs;
      b = rt;
      case (op)
         MULT: begin
            sp = longint'(a) * longint'(b);
            {m_hi, m_lo} = sp;
         end
         MULTU: begin
            up = {32'b0, rs} * {32'b0, rt};
            {m_hi, m_lo} = up;
         end
         DIV: begin
            if (rt == '0) begin m_lo = '1; m_hi = rs; end
            else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
               m_lo = 32'h8000_0000; m_hi = '0;
            end else begin m_lo = a / b; m_hi = a % b; end
         end
         DIVU: begin
            if (rt == '0) begin m_lo = '1; m_hi = rs; end
            else begin m_lo = rs / rt; m_hi = rs % rt; end
         end
         MTHI: m_hi = rs;
         MTLO: m_lo = rs;
         default: ;
      endcase
   endfunction

   task automatic run_long(input logic [3:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
      drive(op, rs, rt);
      step();
      drive(NONE, '0, '0);
      model_apply(op, rs, rt);
   endtask

   task automatic wait_idle();
      int i = 0;
      while (bus.o_busy && i < 50) begin step(); i++; end
      n_cmp++;
      if (bus.o_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL wait_idle: o_busy=%b after %0d cycles, want 0", bus.o_busy, i);
      end
   endtask

   task automatic read_mf(input logic [3:0] op, input string name);
      sb_q.push_back((op == MFHI) ? m_hi : m_lo);
      drive(op, '0, '0);
      step();
      drive(NONE, '0, '0);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (bus.o_rd_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_valid: o_rd_valid=%b want 1", name, bus.o_rd_valid);
      end
      n_cmp++;
      if (bus.o_rd_val !== exp_v) begin
         n_bad++;
         $display("FAIL %s: o_rd_val=%h want %h", name, bus.o_rd_val, exp_v);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(NONE, '0, '0);
      step();
      step();
      n_cmp++;
      if (bus.o_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", bus.o_stall); end
      n_cmp++;
      if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
      n_cmp++;
      if (bus.o_rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", bus.o_rd_valid); end
      n_cmp++;
      if (bus.o_rd_val !== '0) begin n_bad++; $display("FAIL reset_rd_val: got %h want 0", bus.o_rd_val); end
      rst = 1'b0;
      m_hi = '0;
      m_lo = '0;
      read_mf(MFHI, "reset_hi");
      read_mf(MFLO, "reset_lo");
   endtask

   task automatic test_mult();
      int busy_n = 0;
      run_long(MULT, 32'hFFFF_FFFD, 32'd7);
      for (int i = 0; i < 50 && bus.o_busy; i++) begin busy_n++; step(); end
      n_cmp++;
      if (busy_n != 33) begin n_bad++; $display("FAIL mult_busy_cycles: got %0d want 33", busy_n); end
      read_mf(MFHI, "mult_hi");
      read_mf(MFLO, "mult_lo");
   endtask

   task automatic test_multu_mf();
      int stalls = 0;
      drive(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      step();
      model_apply(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      drive(MFHI, '0, '0);
      sb_q.push_back(m_hi);
      #1;
      for (int i = 0; i < 50 && bus.o_stall; i++) begin
         stalls++;
         @(posedge clk);
         #2;
      end
      n_cmp++;
      if (stalls != 33) begin n_bad++; $display("FAIL multu_stall_cycles: got %0d want 33", stalls); end
      step();
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (bus.o_rd_valid !== 1'b1 || bus.o_rd_val !== exp_v) begin
         n_bad++;
         $display("FAIL multu_mfhi: valid=%b val=%h want valid=1 val=%h", bus.o_rd_valid, bus.o_rd_val, exp_v);
      end
      drive(MFLO, '0, '0);
      sb_q.push_back(m_lo);
      step();
      drive(NONE, '0, '0);
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (bus.o_rd_valid !== 1'b1 || bus.o_rd_val !== exp_v) begin
         n_bad++;
         $display("FAIL multu_mflo: valid=%b val=%h want valid=1 val=%h", bus.o_rd_valid, bus.o_rd_val, exp_v);
      end
      step();
      n_cmp++;
      if (bus.o_rd_valid !== 1'b0) begin n_bad++; $display("FAIL multu_clear: valid=%b want 0", bus.o_rd_valid); end
   endtask

   task automatic test_div();
      run_long(DIV, 32'hFFFF_FFF9, 32'd2);
      wait_idle();
      read_mf(MFLO, "div_neg_lo");
      read_mf(MFHI, "div_neg_hi");
      run_long(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle();
      read_mf(MFLO, "div_ovf_lo");
      read_mf(MFHI, "div_ovf_hi");
      run_long(DIV, 32'hFFFF_FFF9, 32'd0);
      wait_idle();
      read_mf(MFLO, "div_zero_s_lo");
      read_mf(MFHI, "div_zero_s_hi");
   endtask

   task automatic test_divu_zero_mt();
      run_long(DIVU, 32'd5, 32'd0);
      wait_idle();
      read_mf(MFLO, "divu_zero_lo");
      read_mf(MFHI, "divu_zero_hi");
      drive(MTLO, 32'h0000_1234, '0);
      #1;
      n_cmp++;
      if (bus.o_stall !== 1'b0) begin n_bad++; $display("FAIL mtlo_stall: got %b want 0", bus.o_stall); end
      step();
      model_apply(MTLO, 32'h0000_1234, '0);
      read_mf(MFLO, "mtlo_mflo");
      drive(MTHI, 32'h5A5A_0F0F, '0);
      step();
      model_apply(MTHI, 32'h5A5A_0F0F, '0);
      read_mf(MFHI, "mthi_mfhi");
   endtask

   task automatic test_mf_stall();
      drive(MTLO, 32'hCAFE_0001, '0);
      step();
      model_apply(MTLO, 32'hCAFE_0001, '0);
      sb_q.push_back(m_lo);
      drive(MFLO, '0, '0);
      step();
      exp_v = sb_q.pop_front();
      bus.i_core_stall = 1'b1;
      drive(MFHI, '0, '0);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (bus.o_rd_valid !== 1'b1 || bus.o_rd_val !== exp_v) begin
            n_bad++;
            $display("FAIL mf_hold_%0d: valid=%b val=%h want valid=1 val=%h", i, bus.o_rd_valid, bus.o_rd_val, exp_v);
         end
         step();
      end
      n_cmp++;
      if (bus.o_rd_valid !== 1'b1 || bus.o_rd_val !== exp_v) begin
         n_bad++;
         $display("FAIL mf_hold_end: valid=%b val=%h want valid=1 val=%h", bus.o_rd_valid, bus.o_rd_val, exp_v);
      end
      bus.i_core_stall = 1'b0;
      drive(NONE, '0, '0);
      step();
      n_cmp++;
      if (bus.o_rd_valid !== 1'b0) begin n_bad++; $display("FAIL mf_release: valid=%b want 0", bus.o_rd_valid); end
   endtask

   task automatic test_nullify();
      bus.i_nullify = 1'b1;
      drive(MULT, 32'd5, 32'd6);
      step();
      n_cmp++;
      if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL nullify_busy: got %b want 0", bus.o_busy); end
      bus.i_nullify = 1'b0;
      drive(NONE, '0, '0);
      read_mf(MFLO, "nullify_lo");
      run_long(DIVU, 32'd100, 32'd7);
      drive(MFHI, '0, '0);
      bus.i_nullify = 1'b1;
      #1;
      n_cmp++;
      if (bus.o_stall !== 1'b0) begin n_bad++; $display("FAIL nullify_drops_stall: got %b want 0", bus.o_stall); end
      bus.i_nullify = 1'b0;
      #1;
      n_cmp++;
      if (bus.o_stall !== 1'b1) begin n_bad++; $display("FAIL mf_hazard_stall: got %b want 1", bus.o_stall); end
      drive(NONE, '0, '0);
      wait_idle();
      read_mf(MFHI, "divu_hi");
      read_mf(MFLO, "divu_lo");
   endtask

   task automatic test_reset_mid_div();
      run_long(DIV, 32'h1234_5678, 32'd3);
      for (int i = 0; i < 9; i++) step();
      rst = 1'b1;
      step();
      drive(MFHI, '0, '0);
      #1;
      n_cmp++;
      if (bus.o_busy !== 1'b0 || bus.o_stall !== 1'b0 || bus.o_rd_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_flags: busy=%b stall=%b valid=%b want 0/0/0", bus.o_busy, bus.o_stall, bus.o_rd_valid);
      end
      drive(NONE, '0, '0);
      rst = 1'b0;
      m_hi = '0;
      m_lo = '0;
      read_mf(MFHI, "midrst_hi");
      read_mf(MFLO, "midrst_lo");
      run_long(MULT, 32'h7FFF_FFFF, 32'h8000_0000);
      wait_idle();
      read_mf(MFHI, "postrst_mult_hi");
      read_mf(MFLO, "postrst_mult_lo");
   endtask

   task automatic test_back_to_back();
      logic [3:0] op;
      logic [W-1:0] rs, rt;
      for (int k = 0; k < 8; k++) begin
         op = 4'(MULT + 4'($urandom_range(0, 3)));
         rs = $urandom();
         rt = (k == 3) ? '0 : ((k % 2 == 0) ? W'($urandom_range(1, 300)) : $urandom());
         run_long(op, rs, rt);
         sb_q.push_back(m_lo);
         drive(MFLO, '0, '0);
         #1;
         for (int i = 0; i < 50 && bus.o_stall; i++) begin
            @(posedge clk);
            #2;
         end
         n_cmp++;
         if (bus.o_stall !== 1'b0) begin n_bad++; $display("FAIL b2b_%0d_timeout: stall=%b want 0", k, bus.o_stall); end
         step();
         exp_v = sb_q.pop_front();
         n_cmp++;
         if (bus.o_rd_valid !== 1'b1 || bus.o_rd_val !== exp_v) begin
            n_bad++;
            $display("FAIL b2b_%0d_lo: op=%0d rs=%h rt=%h valid=%b val=%h want %h", k, op, rs, rt,
                     bus.o_rd_valid, bus.o_rd_val, exp_v);
         end
         read_mf(MFHI, "b2b_hi");
      end
   endtask

   initial begin
      bus.i_core_stall = 1'b0;
      bus.i_nullify    = 1'b0;
      drive(NONE, '0, '0);
      test_reset();
      test_mult();
      test_multu_mf();
      test_div();
      test_divu_zero_mt();
      test_mf_stall();
      test_nullify();
      test_reset_mid_div();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uparc_imuldiv_ctrl.md
Name: uparc_imuldiv_ctrl

Overview:
Sequencer for the integer multiply/divide resource beside the execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO ops from decode and runs a radix-2 iterative multiply or restoring divide over the shared HI/LO registers. It stalls the pipeline on structural or data hazards and returns MFHI/MFLO results to execute through the rd_val/rd_valid override path.

Parameters:
- REG_WIDTH, 32, operand/HI/LO width; iteration count equals REG_WIDTH.
- CNT_WIDTH, 5, iteration counter width; must equal clog2(REG_WIDTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_core_stall  in  1  pipeline stall from other sources (exec/mem/fetch); no new op is accepted while high
- i_nullify  in  1  current decode op is squashed; treat as NONE
- i_op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9-15 treated as NONE
- i_rs_val  in  REG_WIDTH  rs operand (dividend / multiplicand / MT source)
- i_rt_val  in  REG_WIDTH  rt operand (divisor / multiplier)
- o_stall  out  1  hazard stall request to the control unit
- o_rd_val  out  REG_WIDTH  MFHI/MFLO result to execute
- o_rd_valid  out  1  o_rd_val valid; execute selects it over the ALU result
- o_busy  out  1  iterative operation in progress (debug/visibility)

Behaviour:
- Reset: state IDLE, HI=LO=0, counter=0. o_stall=0, o_rd_val=0, o_rd_valid=0, o_busy=0. Reset mid-operation aborts immediately and discards the partial result.
- Accept condition: an op is accepted on a rising edge with !i_core_stall && !o_stall && !i_nullify && op!=NONE.
- States:
  - IDLE: MULT/MULTU -> MUL; DIV/DIVU -> DIV. In IDLE, MT*/MF* complete in a single cycle.
  - MUL: 32 iterations, one per cycle; shift-add on absolute values into a {HI,LO} accumulator. Counter counts 31 down to 0; at 0 -> FIX.
  - DIV: 32 iterations of restoring division on absolute values. Counter counts 31 down to 0; at 0 -> FIX.
  - FIX: one cycle. Applies the sign correction, writes HI/LO -> IDLE.
  - Latency: accept at edge T; HI/LO valid after edge T+33. o_busy is high in MUL, DIV and FIX.
  - Iteration continues during i_core_stall; the resource is not frozen by pipeline stalls.
- Sign rules:
  - On accept, signed ops capture the operand signs and convert operands to magnitudes; unsigned ops use the operands raw.
  - MULT: {HI,LO} negated if sign(rs)^sign(rt).
  - DIV: LO (quotient) negated if sign(rs)^sign(rt); HI (remainder) takes the sign of rs.
  - 0x80000000 / -1 (signed): LO=0x80000000, HI=0.
  - Divisor 0, any signedness: LO=0xFFFFFFFF, HI=rs as issued; FIX performs no negation.
- MTHI/MTLO: write HI/LO with rs on the accept edge.
- MFHI/MFLO:
  - On the accept edge, o_rd_val takes HI/LO and o_rd_valid=1.
  - The pair holds while i_core_stall=1, then clears to o_rd_valid=0 on the first unstalled edge with no new MF accepted.
  - Back-to-back MFs keep o_rd_valid=1 with the new value.
- Hazards (o_stall is combinational, asserted when o_busy and any of):
  - op is MF*: data hazard;
  - op is MT*, MULT*, DIV*: structural hazard.
  - i_op=NONE or i_nullify never stalls.
- Stall release: o_stall deasserts in the cycle after FIX, i.e. in IDLE. The waiting op is then accepted on that edge, so MF returns the final HI/LO.
- Simultaneous events: while in FIX, a waiting op remains stalled. Nullify in the same cycle as the stall drops the stall.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=7, no further ops -> at T+33: HI=0xFFFFFFFF, LO=0xFFFFFFEB; o_busy high for exactly 33 cycles.
- MULTU rs=rt=0xFFFFFFFF, then MFHI and MFLO issued immediately -> o_stall held until IDLE; then o_rd_val=0xFFFFFFFE with o_rd_valid=1, next cycle o_rd_val=0x00000001.
- DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=5, rt=0 -> LO=0xFFFFFFFF, HI=5. MTLO rs=0x1234 in IDLE, then MFLO -> o_rd_val=0x1234 in one cycle with no stall.
- MFLO with i_core_stall=1 for 3 cycles -> o_rd_valid/o_rd_val held all 3 cycles, cleared on the first unstalled edge. MULT with i_nullify=1 -> no state change, o_busy stays 0.
- rst asserted 10 cycles into DIV -> next edge: IDLE, HI=LO=0, o_stall=o_busy=o_rd_valid=0. A new MULT accepted right after reset completes correctly.
